// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared constants and queue entry layout for the instruction prefetch block
package if_pkg;

    localparam logic [31:0] IF_RESET_PC = 32'hbfc0_0000;
    localparam logic [31:0] IF_EXC_PC   = 32'hbfc0_0380;
    localparam logic [31:0] IF_NOP      = 32'h0000_0000;

    // Queue entry at the default 32-bit width; the FIFO stores the same fields packed in this order
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } if_entry_t;

endpackage

// File: rtl/if_fifo.sv
// rtl/if_fifo.sv - synchronous DEPTH-entry queue with flush and same-cycle push/pop
module if_fifo #(
    parameter int DW    = 64,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          head_valid,
    output logic [DW-1:0] head_data,
    output logic [CW-1:0] count
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          do_pop;

    assign do_pop     = pop && (cnt != '0);
    assign head_valid = (cnt != '0);
    assign head_data  = mem[rd_ptr];
    assign count      = cnt;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Flush wins over a same-cycle push: the entry belongs to the abandoned stream
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/if_prefetch.sv
// rtl/if_prefetch.sv - instruction fetch PC, request issue and response queue; IF_ADEL_CHECK_EN enables misaligned-PC faults
module if_prefetch
    import if_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(IF_RESET_PC),
    parameter logic [WIDTH-1:0] EXC_PC   = WIDTH'(IF_EXC_PC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exc_req,
    input  logic             eret_req,
    input  logic [WIDTH-1:0] epc,
    input  logic             br_valid,
    input  logic [WIDTH-1:0] br_target,
    output logic             inst_req,
    output logic [WIDTH-1:0] inst_addr,
    input  logic             inst_addr_ok,
    input  logic [WIDTH-1:0] inst_rdata,
    input  logic             inst_data_ok,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_instr,
    output logic             out_adel
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef IF_ADEL_CHECK_EN
    localparam int EW = 2 * WIDTH + 1;
`else
    localparam int EW = 2 * WIDTH;
`endif

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] resp_pc;
    logic [CW-1:0]    outstanding;
    logic [CW-1:0]    outstanding_next;
    logic [CW-1:0]    drop_cnt;
    logic [CW-1:0]    occupancy;
    logic [CW:0]      inflight;
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;
    logic             fetch_hold;
    logic             accept;
    logic             dropping;
    logic             push;
    logic [EW-1:0]    push_data;
    logic             head_valid;
    logic [EW-1:0]    head_data;

    always_comb begin
        redirect_pc = br_target;
        if (exc_req) begin
            redirect_pc = EXC_PC;
        end else if (eret_req) begin
            redirect_pc = epc;
        end
    end

    assign redirect  = exc_req || eret_req || br_valid;
    assign inflight  = {1'b0, occupancy} + {1'b0, outstanding};
    assign inst_req  = !rst && !redirect && !fetch_hold && (inflight < (CW + 1)'(DEPTH));
    assign inst_addr = pc_q;
    assign accept    = inst_req && inst_addr_ok;
    assign dropping  = inst_data_ok && (drop_cnt != '0);

    assign outstanding_next = outstanding + CW'(accept) - CW'(inst_data_ok);

`ifdef IF_ADEL_CHECK_EN
    logic misaligned;
    logic adel_done;
    logic adel_push;

    // The fault entry waits for older responses so it lands behind them in program order
    assign misaligned = (pc_q[1:0] != 2'b00);
    assign adel_push  = misaligned && !adel_done && !redirect && !rst
                        && (outstanding == '0) && (occupancy < CW'(DEPTH));
    assign fetch_hold = misaligned;
    assign push       = (inst_data_ok && !dropping) || adel_push;
    assign push_data  = adel_push ? {pc_q, WIDTH'(IF_NOP), 1'b1}
                                  : {resp_pc, inst_rdata, 1'b0};
    assign out_pc     = head_data[EW-1 -: WIDTH];
    assign out_instr  = head_data[WIDTH:1];
    assign out_adel   = head_valid && head_data[0] && !rst;

    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            adel_done <= 1'b0;
        end else if (adel_push) begin
            adel_done <= 1'b1;
        end
    end
`else
    assign fetch_hold = 1'b0;
    assign push       = inst_data_ok && !dropping;
    assign push_data  = {resp_pc, inst_rdata};
    assign out_pc     = head_data[EW-1 -: WIDTH];
    assign out_instr  = head_data[WIDTH-1:0];
    assign out_adel   = 1'b0;
`endif

    assign out_valid = head_valid && !rst;

    // resp_pc tracks the PC of the next kept response, so request PCs need no storage
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect) begin
                pc_q     <= redirect_pc;
                resp_pc  <= redirect_pc;
                drop_cnt <= outstanding_next;
            end else begin
                if (accept) begin
                    pc_q <= pc_q + WIDTH'(4);
                end
                if (dropping) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end else if (inst_data_ok) begin
                    resp_pc <= resp_pc + WIDTH'(4);
                end
            end
        end
    end

    if_fifo #(
        .DW    (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect),
        .push       (push),
        .push_data  (push_data),
        .pop        (out_valid && out_ready),
        .head_valid (head_valid),
        .head_data  (head_data),
        .count      (occupancy)
    );

endmodule

// File: tb/tb_if_prefetch.sv
// tb/tb_if_prefetch.sv - self-checking bench for if_prefetch against a queue-based fetch model
module tb_if_prefetch;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic        br_valid;
    logic [31:0] br_target;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_adel;

    if_prefetch dut (
        .clk          (clk),
        .rst          (rst),
        .exc_req      (exc_req),
        .eret_req     (eret_req),
        .epc          (epc),
        .br_valid     (br_valid),
        .br_target    (br_target),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_rdata   (inst_rdata),
        .inst_data_ok (inst_data_ok),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_instr    (out_instr),
        .out_adel     (out_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: memory holds accepted requests tagged with the redirect epoch they belong to
    logic [31:0] mem_addr [$];
    int          mem_ep   [$];
    logic [31:0] q_pc     [$];
    logic [31:0] m_pc;
    int          epoch;
    bit          model_on;
    int          n_acc_obs;
    int          vectors;
    int          errors;

    function automatic logic [31:0] fdata(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5a5a_c3c3;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_redirects();
        exc_req  = 1'b0;
        eret_req = 1'b0;
        br_valid = 1'b0;
    endtask

    task automatic cycle(input bit dok_allow);
        logic [31:0] a;
        int          e;
        bit          redir;
        bit          exp_req;
        if (dok_allow && mem_addr.size() > 0) begin
            inst_data_ok = 1'b1;
            inst_rdata   = fdata(mem_addr[0]);
        end else begin
            inst_data_ok = 1'b0;
            inst_rdata   = $urandom;
        end
        #1;
        if (inst_req && inst_addr_ok) n_acc_obs++;
        if (model_on) begin
            redir   = exc_req || eret_req || br_valid;
            exp_req = !redir && (q_pc.size() + mem_addr.size() < DEPTH);
            chk("inst_req", 64'(inst_req), 64'(exp_req));
            chk("inst_addr", 64'(inst_addr), 64'(m_pc));
            chk("out_valid", 64'(out_valid), 64'(q_pc.size() > 0));
            if (q_pc.size() > 0) begin
                chk("out_pc", 64'(out_pc), 64'(q_pc[0]));
                chk("out_instr", 64'(out_instr), 64'(fdata(q_pc[0])));
            end
            chk("out_adel", 64'(out_adel), 64'(0));
            if (q_pc.size() > 0 && out_ready) void'(q_pc.pop_front());
            if (inst_data_ok) begin
                a = mem_addr.pop_front();
                e = mem_ep.pop_front();
                if (e == epoch) q_pc.push_back(a);
            end
            if (exp_req && inst_addr_ok) begin
                mem_addr.push_back(m_pc);
                mem_ep.push_back(epoch);
                m_pc = m_pc + 32'd4;
            end
            if (redir) begin
                q_pc.delete();
                epoch++;
                m_pc = exc_req ? 32'hbfc0_0380 : (eret_req ? epc : br_target);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        clear_redirects();
        epc          = '0;
        br_target    = '0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = '0;
        out_ready    = 1'b0;
        model_on     = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_inst_req", 64'(inst_req), 64'(0));
            chk("rst_out_valid", 64'(out_valid), 64'(0));
            chk("rst_out_adel", 64'(out_adel), 64'(0));
            chk("rst_pc", 64'(inst_addr), 64'h0000_0000_bfc0_0000);
        end
        rst = 1'b0;
        mem_addr.delete();
        mem_ep.delete();
        q_pc.delete();
        m_pc      = 32'hbfc0_0000;
        epoch     = 0;
        n_acc_obs = 0;
        model_on  = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        int budget;
        budget = 30;
        while (!out_valid && budget > 0) begin
            cycle(1'b1);
            budget--;
        end
        chk(tag, 64'(out_valid), 64'(1));
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst     = 1'b1;

        // Streaming with immediate acceptance and one-cycle responses
        do_reset();
        inst_addr_ok = 1'b1;
        out_ready    = 1'b1;
        repeat (14) cycle(1'b1);

        // Decode stalled: capacity caps accepts at DEPTH and the head holds
        do_reset();
        inst_addr_ok = 1'b1;
        out_ready    = 1'b0;
        repeat (10) cycle(1'b1);
        chk("stall_accepts", 64'(n_acc_obs), 64'(DEPTH));
        chk("stall_req_low", 64'(inst_req), 64'(0));
        chk("stall_head", 64'(out_pc), 64'h0000_0000_bfc0_0000);
        out_ready = 1'b1;
        repeat (10) cycle(1'b1);

        // Branch with three requests outstanding: their responses are discarded
        do_reset();
        inst_addr_ok = 1'b1;
        out_ready    = 1'b1;
        repeat (3) cycle(1'b0);
        br_valid  = 1'b1;
        br_target = 32'h8000_1000;
        cycle(1'b0);
        clear_redirects();
        wait_valid("br_wait");
        chk("br_first_pc", 64'(out_pc), 64'h0000_0000_8000_1000);
        repeat (4) cycle(1'b1);

        // All three redirects at once: exception wins and the queue empties
        exc_req   = 1'b1;
        eret_req  = 1'b1;
        epc       = 32'h8000_2000;
        br_valid  = 1'b1;
        br_target = 32'h8000_3000;
        cycle(1'b1);
        clear_redirects();
        chk("prio_pc", 64'(inst_addr), 64'h0000_0000_bfc0_0380);
        chk("prio_flush", 64'(out_valid), 64'(0));
        repeat (6) cycle(1'b1);

        // Head held while responses arrive, then drained with overlapping push/pop
        do_reset();
        inst_addr_ok = 1'b1;
        out_ready    = 1'b0;
        repeat (6) cycle(1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            inst_addr_ok = ($urandom_range(0, 3) != 0);
            cycle(1'b1);
        end

        // Redirect under full back-pressure with DEPTH outstanding is not lost
        do_reset();
        inst_addr_ok = 1'b1;
        out_ready    = 1'b0;
        repeat (4) cycle(1'b0);
        br_valid  = 1'b1;
        br_target = 32'h8000_4000;
        cycle(1'b0);
        clear_redirects();
        out_ready = 1'b1;
        wait_valid("full_br_wait");
        chk("full_br_pc", 64'(out_pc), 64'h0000_0000_8000_4000);

        // Randomized traffic with occasional redirects
        do_reset();
        for (int i = 0; i < 600; i++) begin
            inst_addr_ok = ($urandom_range(0, 3) != 0);
            out_ready    = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 24) == 0) begin
                exc_req   = ($urandom_range(0, 3) == 0);
                eret_req  = ($urandom_range(0, 2) == 0);
                br_valid  = 1'b1;
                epc       = $urandom & 32'hffff_fffc;
                br_target = $urandom & 32'hffff_fffc;
            end
            cycle($urandom_range(0, 2) != 0);
            clear_redirects();
        end

`ifdef IF_ADEL_CHECK_EN
        // Misaligned target: no requests, one fault entry, then resume on exception
        do_reset();
        model_on     = 1'b0;
        inst_addr_ok = 1'b1;
        out_ready    = 1'b0;
        br_valid     = 1'b1;
        br_target    = 32'h8000_0002;
        cycle(1'b0);
        clear_redirects();
        n_acc_obs = 0;
        repeat (6) cycle(1'b0);
        chk("adel_no_req", 64'(n_acc_obs), 64'(0));
        chk("adel_valid", 64'(out_valid), 64'(1));
        chk("adel_pc", 64'(out_pc), 64'h0000_0000_8000_0002);
        chk("adel_flag", 64'(out_adel), 64'(1));
        chk("adel_instr", 64'(out_instr), 64'(0));
        exc_req = 1'b1;
        cycle(1'b0);
        clear_redirects();
        chk("adel_resume_pc", 64'(inst_addr), 64'h0000_0000_bfc0_0380);
        chk("adel_resume_req", 64'(inst_req), 64'(1));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
